// File: rtl/weighted_round_robin.sv
// rtl/weighted_round_robin.sv - weighted round-robin arbiter with registered grant
//
// Purpose:
//   Arbitrates REQUEST_WIDTH requesters onto one shared resource. The current
//   owner keeps the grant for up to weight+1 consecutive cycles. After that, the
//   grant rotates to the next requester in circular order. All outputs come
//   straight from flops, so there is no combinational input-to-output path.
//
// Optional build macro:
//   WEIGHTED_ROUND_ROBIN_LOCK_EN - adds i_lock. While the owner is granted and
//   still requesting, i_lock pins the grant to it and freezes its credit.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   i_request      in   [REQUEST_WIDTH]              request vector, bit i = requester i
//   i_weight       in   [REQUEST_WIDTH*WEIGHT_WIDTH] packed weights, slice i = requester i
//   i_lock         in   1 (LOCK_EN builds only)      hold current owner, freeze credit
//   o_grant_valid  out  1                            a grant is active this cycle
//   o_grant        out  [GRANT_WIDTH]                encoded granted index
//   o_grant_onehot out  [REQUEST_WIDTH]              one-hot grant, zero when not valid

module weighted_round_robin #(
  parameter int REQUEST_WIDTH = 8,
  parameter int WEIGHT_WIDTH  = 4,
  localparam int GRANT_WIDTH  = $clog2(REQUEST_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [REQUEST_WIDTH-1:0]              i_request,
  input  logic [REQUEST_WIDTH*WEIGHT_WIDTH-1:0] i_weight,
`ifdef WEIGHTED_ROUND_ROBIN_LOCK_EN
  input  logic                                  i_lock,
`endif
  output logic                                  o_grant_valid,
  output logic [GRANT_WIDTH-1:0]                o_grant,
  output logic [REQUEST_WIDTH-1:0]              o_grant_onehot
);

  logic [GRANT_WIDTH-1:0]   owner_q, owner_d;
  logic [WEIGHT_WIDTH-1:0]  credit_q, credit_d;
  logic                     valid_q, valid_d;
  logic [GRANT_WIDTH-1:0]   grant_q, grant_d;
  logic [REQUEST_WIDTH-1:0] onehot_q, onehot_d;

  logic [WEIGHT_WIDTH-1:0]  weight_arr [REQUEST_WIDTH];
  logic [WEIGHT_WIDTH-1:0]  owner_weight;
  logic                     owner_req;
  logic                     lock_hold;
  logic [GRANT_WIDTH-1:0]   next_idx;
  logic                     next_found;

  for (genvar g = 0; g < REQUEST_WIDTH; g++) begin : g_weight
    assign weight_arr[g] = i_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // The weight is looked up live, so lowering it mid-turn shortens the turn.
  assign owner_weight = weight_arr[owner_q];
  assign owner_req    = i_request[owner_q];

`ifdef WEIGHTED_ROUND_ROBIN_LOCK_EN
  assign lock_hold = valid_q & owner_req & i_lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Circular search starting at owner+1 and ending with the owner itself.
  // This lets a sole requester win again right after its turn expires.
  always_comb begin
    int sum;
    next_idx   = owner_q;
    next_found = 1'b0;
    sum        = 0;
    for (int k = 1; k <= REQUEST_WIDTH; k++) begin
      sum = int'(owner_q) + k;
      if (sum >= REQUEST_WIDTH) sum = sum - REQUEST_WIDTH;
      if (!next_found && i_request[GRANT_WIDTH'(sum)]) begin
        next_found = 1'b1;
        next_idx   = GRANT_WIDTH'(sum);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= GRANT_WIDTH'(REQUEST_WIDTH - 1);
      credit_q <= '0;
      valid_q  <= 1'b0;
      grant_q  <= '0;
      onehot_q <= '0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
      onehot_q <= onehot_d;
    end
  end

  // Next-state decision, in priority order: lock, hold, rotate, idle.
  always_comb begin
    owner_d  = owner_q;
    credit_d = credit_q;
    valid_d  = valid_q;
    grant_d  = grant_q;
    onehot_d = onehot_q;
    if (lock_hold) begin
      valid_d = 1'b1;
    end else if (valid_q && owner_req && (credit_q < owner_weight)) begin
      // The owner has credit left in this turn. HOLD requires credit < weight,
      // so the increment can never wrap.
      credit_d = credit_q + 1'b1;
    end else if (next_found) begin
      owner_d  = next_idx;
      credit_d = '0;
      valid_d  = 1'b1;
      grant_d  = next_idx;
      onehot_d = '0;
      onehot_d[next_idx] = 1'b1;
    end else begin
      // Idle: o_grant and the owner pointer are kept, so rotation later
      // resumes after the last owner.
      valid_d  = 1'b0;
      onehot_d = '0;
    end
  end

  // Outputs.
  always_comb begin
    o_grant_valid  = valid_q;
    o_grant        = grant_q;
    o_grant_onehot = onehot_q;
  end

endmodule

// File: tb/tb_weighted_round_robin.sv
// tb/tb_weighted_round_robin.sv - self-checking bench for weighted_round_robin

module tb_weighted_round_robin;

  localparam int N = 8;
  localparam int W = 4;
  localparam int G = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wt = '0;
  logic           lock = 1'b0;
  logic           o_grant_valid;
  logic [G-1:0]   o_grant;
  logic [N-1:0]   o_grant_onehot;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model. It tracks how many cycles of the current turn have been
  // used, with a turn allowed weight+1 cycles.
  int m_owner;
  int m_run;
  bit m_valid;
  int m_grant;

  weighted_round_robin #(.REQUEST_WIDTH(N), .WEIGHT_WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_request(req),
    .i_weight(wt),
`ifdef WEIGHTED_ROUND_ROBIN_LOCK_EN
    .i_lock(lock),
`endif
    .o_grant_valid(o_grant_valid),
    .o_grant(o_grant),
    .o_grant_onehot(o_grant_onehot)
  );

  always #5 clk = ~clk;

  function automatic int wof(int i);
    return int'(wt[i*W +: W]);
  endfunction

  task automatic set_w(int i, int v);
    wt[i*W +: W] = W'(v);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = N - 1;
    m_run   = 0;
    m_valid = 0;
    m_grant = 0;
  endtask

  task automatic model_edge();
    bit locked;
    locked = 0;
`ifdef WEIGHTED_ROUND_ROBIN_LOCK_EN
    locked = m_valid && req[m_owner] && lock;
`endif
    if (locked) begin
      // grant and turn length frozen
    end else if (m_valid && req[m_owner] && (m_run < wof(m_owner) + 1)) begin
      m_run++;
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(m_owner + k) % N]) begin
          m_owner = (m_owner + k) % N;
          break;
        end
      end
      m_run   = 1;
      m_valid = 1;
      m_grant = m_owner;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check_model(string tag);
    logic [N-1:0] exp_oh;
    exp_oh = m_valid ? (N'(1) << m_grant) : '0;
    chk({tag, ".valid"}, 32'(o_grant_valid), 32'(m_valid));
    chk({tag, ".grant"}, 32'(o_grant), 32'(m_grant));
    chk({tag, ".onehot"}, 32'(o_grant_onehot), 32'(exp_oh));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_seq[$];

  initial begin
    model_reset();
    #2;
    check_model("por");

    // 1: idle after reset
    do_reset();
    req = '0;
    for (int i = 0; i < 5; i++) tick("idle");
    chk("idle_valid", 32'(o_grant_valid), 32'd0);

    // 2: plain round robin
    do_reset();
    wt = '0;
    req = 8'hFF;
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    foreach (exp_seq[i]) begin
      tick("rr");
      chk("rr_seq", 32'(o_grant), 32'(exp_seq[i]));
      chk("rr_oh", 32'(o_grant_onehot), 32'(8'd1 << exp_seq[i]));
    end

    // 3: weighted r0=2, r3=0
    do_reset();
    wt = '0;
    set_w(0, 2);
    set_w(3, 0);
    req = 8'b0000_1001;
    exp_seq = '{0, 0, 0, 3, 0, 0, 0, 3};
    foreach (exp_seq[i]) begin
      tick("wrr");
      chk("wrr_seq", 32'(o_grant), 32'(exp_seq[i]));
    end

    // 4: early release of r2, then a fresh turn for r2
    do_reset();
    wt = '0;
    set_w(2, 5);
    req = 8'b0000_0100;
    tick("rel");
    tick("rel");
    chk("rel_pre", 32'(o_grant), 32'd2);
    @(negedge clk);
    req = 8'b0010_0000;
    tick("rel");
    chk("rel_move", 32'(o_grant), 32'd5);
    @(negedge clk);
    req = 8'b0010_0100;
    exp_seq = '{2, 2, 2, 2, 2, 2, 5};
    foreach (exp_seq[i]) begin
      tick("fresh");
      chk("fresh_seq", 32'(o_grant), 32'(exp_seq[i]));
    end

    // 5: reset mid-turn of r6
    do_reset();
    wt = '0;
    set_w(6, 7);
    req = 8'b0100_0000;
    for (int i = 0; i < 4; i++) tick("r6");
    chk("r6_hold", 32'(o_grant), 32'd6);
    @(negedge clk);
    req = 8'b0100_0100;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    tick("after_rst");
    chk("after_rst_grant", 32'(o_grant), 32'd2);

`ifdef WEIGHTED_ROUND_ROBIN_LOCK_EN
    // 6: lock pins owner
    do_reset();
    wt = '0;
    req = 8'b0000_0110;
    tick("lk");
    chk("lk_first", 32'(o_grant), 32'd1);
    @(negedge clk);
    lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("lk");
      chk("lk_hold", 32'(o_grant), 32'd1);
    end
    @(negedge clk);
    lock = 1'b0;
    tick("lk");
    chk("lk_release", 32'(o_grant), 32'd2);
`endif

    // Randomized phase: live weight changes, sparse and dense requests.
    do_reset();
    for (int i = 0; i < N; i++) set_w(i, $urandom_range(0, 3));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: req = N'($urandom);
        1: req = N'(1) << $urandom_range(0, N - 1);
        2: req = '0;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) set_w($urandom_range(0, N - 1), $urandom_range(0, 15));
`ifdef WEIGHTED_ROUND_ROBIN_LOCK_EN
      lock = ($urandom_range(0, 5) == 0);
`endif
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
